// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// The optional leading-zero mask helper is used only when SEG_SCAN_LZS_EN is defined.
package seg_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_GAP
    } seg_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam int unsigned DIGITS_MIN = 2;
    localparam int unsigned DIGITS_MAX = 8;

    // Walks down from the top digit and marks zero nibbles until the first nonzero one.
    // Digit 0 is never marked.
    function automatic logic [DIGITS_MAX-1:0] lzs_mask(input logic [4*DIGITS_MAX-1:0] data,
                                                       input int unsigned digits);
        logic lead;
        lzs_mask = '0;
        lead     = 1'b1;
        for (int i = DIGITS_MAX - 1; i >= 1; i--) begin
            if (i < int'(digits)) begin
                if (lead && (data[4*i +: 4] == 4'h0)) begin
                    lzs_mask[i] = 1'b1;
                end else begin
                    lead = 1'b0;
                end
            end
        end
    endfunction

endpackage

// File: rtl/seg_scan_div.sv
// Per-digit prescaler: counts 0..DIV-1 while not cleared and flags the terminal count.
module seg_scan_div #(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tc
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tc = (cnt_q == W'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr || tc) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Double-buffered, time-multiplexed scan controller for common-anode 7-segment digits.
// Define SEG_SCAN_LZS_EN to add leading-zero suppression to the displayed mask.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic [DIGITS-1:0]     wr_blank,
    output logic [3:0]            nib,
    input  logic [6:0]            seg_in,
    output logic [6:0]            seg_out,
    output logic [DIGITS-1:0]     an
);

    localparam int unsigned      DW     = $clog2(DIGITS);
    localparam logic [DW-1:0]    D_LAST = DW'(DIGITS - 1);

    seg_state_t               state_q, state_d;
    logic [DW-1:0]            dig_q, dig_d;
    logic [4*DIGITS-1:0]      pend_data_q;
    logic [DIGITS-1:0]        pend_mask_q;
    logic                     pend_v_q, pend_v_d;
    logic [4*DIGITS-1:0]      shd_data_q;
    logic [DIGITS-1:0]        shd_mask_q, new_mask;
    logic [3:0]               nib_q, nib_d;
    logic [4*DIGITS-1:0]      src_data;
    logic                     accept, swap, load_nib, tc;

    assign wr_ready = !pend_v_q;
    assign accept   = wr_valid && !pend_v_q;
    assign nib      = nib_q;

    seg_scan_div #(
        .DIV (DIV)
    ) u_div (
        .clk (clk),
        .rst (rst),
        .clr (state_q != S_ON),
        .tc  (tc)
    );

    always_comb begin
        state_d  = state_q;
        dig_d    = dig_q;
        swap     = 1'b0;
        load_nib = 1'b0;
        case (state_q)
            S_IDLE: begin
                swap = pend_v_q;
                if (en) begin
                    state_d  = S_ON;
                    dig_d    = '0;
                    load_nib = 1'b1;
                end
            end
            S_ON: begin
                if (!en) begin
                    state_d = S_IDLE;
                    dig_d   = '0;
                end else if (tc) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (!en) begin
                    state_d = S_IDLE;
                    dig_d   = '0;
                end else begin
                    state_d  = S_ON;
                    load_nib = 1'b1;
                    // Frame boundary is the only point where a new image may be swapped in.
                    if (dig_q == D_LAST) begin
                        dig_d = '0;
                        swap  = pend_v_q;
                    end else begin
                        dig_d = dig_q + DW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                dig_d   = '0;
            end
        endcase
    end

    always_comb begin
        src_data = swap ? pend_data_q : shd_data_q;
        nib_d    = nib_q;
        if (load_nib) begin
            nib_d = 4'(src_data >> {dig_d, 2'b00});
        end
        pend_v_d = pend_v_q;
        if (accept) begin
            pend_v_d = 1'b1;
        end else if (swap) begin
            pend_v_d = 1'b0;
        end
    end

`ifdef SEG_SCAN_LZS_EN
    logic [4*DIGITS_MAX-1:0] lz_data;
    logic [DIGITS_MAX-1:0]   lz_mask;
    always_comb begin
        lz_data                = '0;
        lz_data[4*DIGITS-1:0]  = pend_data_q;
        lz_mask                = lzs_mask(lz_data, DIGITS);
        new_mask               = pend_mask_q | lz_mask[DIGITS-1:0];
    end
`else
    assign new_mask = pend_mask_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dig_q       <= '0;
            pend_data_q <= '0;
            pend_mask_q <= '0;
            pend_v_q    <= 1'b0;
            shd_data_q  <= '0;
            shd_mask_q  <= '1;
            nib_q       <= 4'h0;
        end else begin
            state_q  <= state_d;
            dig_q    <= dig_d;
            pend_v_q <= pend_v_d;
            nib_q    <= nib_d;
            if (accept) begin
                pend_data_q <= wr_data;
                pend_mask_q <= wr_blank;
            end
            if (swap) begin
                shd_data_q <= pend_data_q;
                shd_mask_q <= new_mask;
            end
        end
    end

    always_comb begin
        an = '1;
        if (state_q == S_ON) begin
            an[dig_q] = 1'b0;
        end
    end

    assign seg_out = ((state_q != S_ON) || shd_mask_q[dig_q]) ? SEG_OFF : seg_in;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, DIV=3: per-cycle vector tables plus
// hand-written frame, reset and (with SEG_SCAN_LZS_EN) leading-zero sequences.
module tb_seg_scan_ctrl;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned DIV    = 3;
    localparam logic [6:0]  OFF    = 7'h7F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_data = '0;
    logic [3:0]  wr_blank = '0;
    logic [3:0]  nib;
    logic [6:0]  seg_in = 7'h12;
    logic [6:0]  seg_out;
    logic [3:0]  an;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        en;
        logic        wv;
        logic [15:0] wdata;
        logic [3:0]  an;
        logic [3:0]  nib;
        logic        lit;
        logic        rdy;
    } vec_t;

    vec_t tbl[$];

    seg_scan_ctrl #(
        .DIGITS (DIGITS),
        .DIV    (DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .wr_blank (wr_blank),
        .nib      (nib),
        .seg_in   (seg_in),
        .seg_out  (seg_out),
        .an       (an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        seg_in = 7'($urandom_range(0, 126));
        #1;
    endtask

    task automatic add(input int n, input logic e, input logic wv, input logic [15:0] wd,
                       input logic [3:0] a, input logic [3:0] nb, input logic lit,
                       input logic rdy);
        vec_t v;
        v.en = e; v.wv = wv; v.wdata = wd; v.an = a; v.nib = nb; v.lit = lit; v.rdy = rdy;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic run_tbl(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            en       = tbl[i].en;
            wr_valid = tbl[i].wv;
            wr_data  = tbl[i].wdata;
            wr_blank = 4'h0;
            step();
            chk($sformatf("%s[%0d].an", tag, i), 32'(an), 32'(tbl[i].an));
            chk($sformatf("%s[%0d].nib", tag, i), 32'(nib), 32'(tbl[i].nib));
            chk($sformatf("%s[%0d].seg", tag, i), 32'(seg_out),
                32'(tbl[i].lit ? seg_in : OFF));
            chk($sformatf("%s[%0d].rdy", tag, i), 32'(wr_ready), 32'(tbl[i].rdy));
        end
        wr_valid = 1'b0;
        tbl.delete();
    endtask

    task automatic write_idle(input logic [15:0] data, input logic [3:0] blank);
        en       = 1'b0;
        wr_valid = 1'b1;
        wr_data  = data;
        wr_blank = blank;
        step();
        chk("wr.rdy_low", 32'(wr_ready), 32'(1'b0));
        wr_valid = 1'b0;
        step();
        chk("wr.rdy_high", 32'(wr_ready), 32'(1'b1));
    endtask

    // Starts from S_IDLE, scans one whole frame and returns to S_IDLE.
    task automatic run_frame(input string tag, input logic [15:0] data, input logic [3:0] dark);
        logic [3:0] a_exp;
        en = 1'b1;
        for (int d = 0; d < 4; d++) begin
            a_exp    = 4'hF;
            a_exp[d] = 1'b0;
            for (int c = 0; c < int'(DIV); c++) begin
                step();
                chk($sformatf("%s.d%0d.an", tag, d), 32'(an), 32'(a_exp));
                chk($sformatf("%s.d%0d.nib", tag, d), 32'(nib), 32'(data[4*d +: 4]));
                chk($sformatf("%s.d%0d.seg", tag, d), 32'(seg_out),
                    32'(dark[d] ? OFF : seg_in));
            end
            step();
            chk($sformatf("%s.gap%0d.an", tag, d), 32'(an), 32'(4'hF));
            chk($sformatf("%s.gap%0d.seg", tag, d), 32'(seg_out), 32'(OFF));
        end
        en = 1'b0;
        step();
        chk($sformatf("%s.idle.an", tag), 32'(an), 32'(4'hF));
    endtask

    initial begin
        logic [3:0] lz70;
        logic [3:0] lz00;
`ifdef SEG_SCAN_LZS_EN
        lz70 = 4'b1100;
        lz00 = 4'b1110;
`else
        lz70 = 4'b0000;
        lz00 = 4'b0000;
`endif
        #1;
        chk("rst.an", 32'(an), 32'(4'hF));
        chk("rst.nib", 32'(nib), 32'(4'h0));
        chk("rst.seg", 32'(seg_out), 32'(OFF));
        chk("rst.rdy", 32'(wr_ready), 32'(1'b1));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Empty image after reset: digits step but stay dark.
        run_frame("dark", 16'h0000, 4'hF);

        // Write while idle, then one full frame.
        add(1, 0, 1, 16'h12A4, 4'hF, 4'h0, 0, 0);
        add(3, 1, 0, 16'h0000, 4'hE, 4'h4, 1, 1);
        add(1, 1, 0, 16'h0000, 4'hF, 4'h4, 0, 1);
        add(3, 1, 0, 16'h0000, 4'hD, 4'hA, 1, 1);
        add(1, 1, 0, 16'h0000, 4'hF, 4'hA, 0, 1);
        add(3, 1, 0, 16'h0000, 4'hB, 4'h2, 1, 1);
        add(1, 1, 0, 16'h0000, 4'hF, 4'h2, 0, 1);
        add(3, 1, 0, 16'h0000, 4'h7, 4'h1, 1, 1);
        add(1, 1, 0, 16'h0000, 4'hF, 4'h1, 0, 1);
        add(1, 1, 0, 16'h0000, 4'hE, 4'h4, 1, 1);
        add(1, 0, 0, 16'h0000, 4'hF, 4'h4, 0, 1);
        run_tbl("idle_wr");

        // Write during digit 1; a second offer is held off until the frame-end swap.
        add(3, 1, 0, 16'h0000, 4'hE, 4'h4, 1, 1);
        add(1, 1, 0, 16'h0000, 4'hF, 4'h4, 0, 1);
        add(1, 1, 0, 16'h0000, 4'hD, 4'hA, 1, 1);
        add(1, 1, 1, 16'h5555, 4'hD, 4'hA, 1, 0);
        add(1, 1, 1, 16'h9999, 4'hD, 4'hA, 1, 0);
        add(1, 1, 1, 16'h9999, 4'hF, 4'hA, 0, 0);
        add(3, 1, 1, 16'h9999, 4'hB, 4'h2, 1, 0);
        add(1, 1, 1, 16'h9999, 4'hF, 4'h2, 0, 0);
        add(3, 1, 1, 16'h9999, 4'h7, 4'h1, 1, 0);
        add(1, 1, 1, 16'h9999, 4'hF, 4'h1, 0, 0);
        add(1, 1, 1, 16'h9999, 4'hE, 4'h5, 1, 1);
        add(1, 1, 0, 16'h0000, 4'hE, 4'h5, 1, 1);
        add(1, 0, 0, 16'h0000, 4'hF, 4'h5, 0, 1);
        run_tbl("scan_wr");

        // Enable dropped on digit 2, then re-raised.
        add(3, 1, 0, 16'h0000, 4'hE, 4'h5, 1, 1);
        add(1, 1, 0, 16'h0000, 4'hF, 4'h5, 0, 1);
        add(3, 1, 0, 16'h0000, 4'hD, 4'h5, 1, 1);
        add(1, 1, 0, 16'h0000, 4'hF, 4'h5, 0, 1);
        add(1, 1, 0, 16'h0000, 4'hB, 4'h5, 1, 1);
        add(1, 0, 0, 16'h0000, 4'hF, 4'h5, 0, 1);
        add(1, 1, 0, 16'h0000, 4'hE, 4'h5, 1, 1);
        add(1, 0, 0, 16'h0000, 4'hF, 4'h5, 0, 1);
        run_tbl("en_drop");

        write_idle(16'h1234, 4'b0010);
        run_frame("blank", 16'h1234, 4'b0010);
        write_idle(16'h0070, 4'b0000);
        run_frame("z0070", 16'h0070, lz70);
        write_idle(16'h0000, 4'b0000);
        run_frame("z0000", 16'h0000, lz00);

        // Asynchronous reset mid-frame with a pending image.
        en = 1'b1;
        for (int i = 0; i < 5; i++) step();
        wr_valid = 1'b1;
        wr_data  = 16'h8888;
        wr_blank = 4'h0;
        step();
        chk("mrst.pending", 32'(wr_ready), 32'(1'b0));
        wr_valid = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("mrst.an", 32'(an), 32'(4'hF));
        chk("mrst.seg", 32'(seg_out), 32'(OFF));
        chk("mrst.rdy", 32'(wr_ready), 32'(1'b1));
        chk("mrst.nib", 32'(nib), 32'(4'h0));
        #2;
        rst = 1'b0;
        en  = 1'b0;
        step();
        chk("mrst.rdy_after", 32'(wr_ready), 32'(1'b1));
        run_frame("mrst", 16'h0000, 4'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
